// File: rtl/internet_pkg.sv
// Shared definitions for the internet link arbiter and its downstream demux:
// channel indices, link data width, FSM state encoding and small helpers.
package internet_pkg;

  // Link data width, shared with internet_demux.
  localparam int DW = 4;

  // Channel indices as driven on Sel.
  localparam logic [1:0] CH_LIB    = 2'd0;
  localparam logic [1:0] CH_FD     = 2'd1;
  localparam logic [1:0] CH_RIBS   = 2'd2;
  localparam logic [1:0] CH_SCHOOL = 2'd3;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;

  // One-hot decode of a channel index.
  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    logic [3:0] oh;
    case (ch)
      CH_LIB:    oh = 4'b0001;
      CH_FD:     oh = 4'b0010;
      CH_RIBS:   oh = 4'b0100;
      CH_SCHOOL: oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // Wrapping increment of a channel index (mod 4).
  function automatic logic [1:0] ch_next(input logic [1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/internet_arbiter_mux_if.sv
// Bus between the four link sources and the arbiter/mux. The master side
// supplies requests and data; the slave side (the arbiter) returns the muxed
// link signals that feed internet_demux.
interface internet_arbiter_mux_if #(
  parameter int DW = 4
);

  logic [3:0]      req;
  logic [4*DW-1:0] data_in;
  logic [DW-1:0]   muxOutput;
  logic            Enable;
  logic [1:0]      Sel;
  logic [3:0]      grant;

  modport master (
    output req,
    output data_in,
    input  muxOutput,
    input  Enable,
    input  Sel,
    input  grant
  );

  modport slave (
    input  req,
    input  data_in,
    output muxOutput,
    output Enable,
    output Sel,
    output grant
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: scans req starting at ptr and
// wrapping mod 4; the first set bit wins.
module rr_arbiter4
  import internet_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic       found_s;
  logic [1:0] idx_s;
  logic [1:0] cand_s;

  // Priority scan from ptr upward; the first requester seen is kept.
  always_comb begin
    found_s = 1'b0;
    idx_s   = CH_LIB;
    cand_s  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_s = ptr + k[1:0];
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
        idx_s   = idx_s;
      end
    end
  end

  assign found = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/internet_arbiter_mux.sv
// Round-robin arbiter and data mux feeding internet_demux. Four sources share
// one link; a grant lasts up to HOLD_CYCLES cycles or until the holder drops
// its request, after which the next requester is granted with no idle bubble.
// All link outputs are registered from next-state values.
module internet_arbiter_mux
  import internet_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DW          = internet_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  internet_arbiter_mux_if.slave  bus
);

  // Counter width covers 0..HOLD_CYCLES-1 with at least one bit.
  localparam int HW = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO   = HW'(0);

  // Registered state.
  state_t        state_r;
  logic [1:0]    rr_ptr_r;
  logic [HW-1:0] hold_cnt_r;
  logic [1:0]    sel_r;
  logic          enable_r;
  logic [DW-1:0] mux_r;
  logic [3:0]    grant_r;

  // Next-state values.
  state_t        state_n_s;
  logic [1:0]    rr_ptr_n_s;
  logic [HW-1:0] hold_cnt_n_s;
  logic [1:0]    sel_n_s;
  logic          enable_n_s;
  logic [DW-1:0] data_sel_s;

  // Arbiter hookup.
  logic          release_s;
  logic [1:0]    arb_ptr_s;
  logic          arb_found_s;
  logic [1:0]    arb_idx_s;

  // A grant ends on timeout or when the holder stops requesting; both at once
  // still count as a single release.
  always_comb begin
    if (state_r == GRANT) begin
      release_s = (hold_cnt_r == HOLD_ZERO) | ~bus.req[sel_r];
    end else begin
      release_s = 1'b0;
    end
  end

  // On a release the scan starts just past the old holder; otherwise from rr_ptr.
  always_comb begin
    if (release_s) begin
      arb_ptr_s = ch_next(sel_r);
    end else begin
      arb_ptr_s = rr_ptr_r;
    end
  end

  rr_arbiter4 u_rr_arbiter4 (
    .req   (bus.req),
    .ptr   (arb_ptr_s),
    .found (arb_found_s),
    .idx   (arb_idx_s)
  );

  // FSM next-state: grant from IDLE, hold/count down in GRANT, hand over or go idle on release.
  always_comb begin
    state_n_s    = state_r;
    rr_ptr_n_s   = rr_ptr_r;
    hold_cnt_n_s = hold_cnt_r;
    sel_n_s      = sel_r;
    enable_n_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_found_s) begin
          state_n_s    = GRANT;
          sel_n_s      = arb_idx_s;
          hold_cnt_n_s = HOLD_RELOAD;
          enable_n_s   = 1'b1;
        end else begin
          state_n_s    = IDLE;
          enable_n_s   = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          rr_ptr_n_s = arb_ptr_s;
          if (arb_found_s) begin
            state_n_s    = GRANT;
            sel_n_s      = arb_idx_s;
            hold_cnt_n_s = HOLD_RELOAD;
            enable_n_s   = 1'b1;
          end else begin
            state_n_s    = IDLE;
            hold_cnt_n_s = HOLD_ZERO;
            enable_n_s   = 1'b0;
          end
        end else begin
          hold_cnt_n_s = hold_cnt_r - HOLD_ONE;
          enable_n_s   = 1'b1;
        end
      end
      default: begin
        state_n_s    = IDLE;
        rr_ptr_n_s   = 2'd0;
        hold_cnt_n_s = HOLD_ZERO;
        sel_n_s      = CH_LIB;
        enable_n_s   = 1'b0;
      end
    endcase
  end

  // Select the next granted channel's data with constant slices.
  always_comb begin
    case (sel_n_s)
      CH_LIB:    data_sel_s = bus.data_in[0*DW +: DW];
      CH_FD:     data_sel_s = bus.data_in[1*DW +: DW];
      CH_RIBS:   data_sel_s = bus.data_in[2*DW +: DW];
      CH_SCHOOL: data_sel_s = bus.data_in[3*DW +: DW];
      default:   data_sel_s = {DW{1'b0}};
    endcase
  end

  // State and output registers; reset wins over everything and drops any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= 2'd0;
      hold_cnt_r <= HOLD_ZERO;
      sel_r      <= CH_LIB;
      enable_r   <= 1'b0;
      mux_r      <= {DW{1'b0}};
      grant_r    <= 4'b0000;
    end else begin
      state_r    <= state_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
      hold_cnt_r <= hold_cnt_n_s;
      sel_r      <= sel_n_s;
      enable_r   <= enable_n_s;
      mux_r      <= enable_n_s ? data_sel_s : {DW{1'b0}};
      grant_r    <= enable_n_s ? ch_onehot(sel_n_s) : 4'b0000;
    end
  end

  assign bus.muxOutput = mux_r;
  assign bus.Enable    = enable_r;
  assign bus.Sel       = sel_r;
  assign bus.grant     = grant_r;

endmodule

// File: tb/tb_internet_arbiter_mux.sv
// Directed bench for internet_arbiter_mux. Two instances share clock and
// stimulus: dut_a with HOLD_CYCLES=4 and dut_b with HOLD_CYCLES=2.
module tb_internet_arbiter_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  req_v;
  logic [15:0] data_v;
  int          n_checks;
  int          n_errors;

  internet_arbiter_mux_if #(.DW(4)) bus_a ();
  internet_arbiter_mux_if #(.DW(4)) bus_b ();

  assign bus_a.req     = req_v;
  assign bus_a.data_in = data_v;
  assign bus_b.req     = req_v;
  assign bus_b.data_in = data_v;

  internet_arbiter_mux #(.HOLD_CYCLES(4), .DW(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  internet_arbiter_mux #(.HOLD_CYCLES(2), .DW(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = 4'b0000;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  // Check all outputs of dut_a against an expected grant (en=0 means idle).
  task automatic expect_a(input string tag, input logic en, input logic [1:0] sel, input logic [3:0] dat);
    check_val({tag, ".en"}, {15'd0, bus_a.Enable}, {15'd0, en});
    if (en) begin
      check_val({tag, ".sel"},   {14'd0, bus_a.Sel},       {14'd0, sel});
      check_val({tag, ".mux"},   {12'd0, bus_a.muxOutput}, {12'd0, dat});
      check_val({tag, ".grant"}, {12'd0, bus_a.grant},     {12'd0, 4'b0001 << sel});
    end else begin
      check_val({tag, ".mux"},   {12'd0, bus_a.muxOutput}, 16'd0);
      check_val({tag, ".grant"}, {12'd0, bus_a.grant},     16'd0);
    end
  endtask

  logic [1:0] rr_sel [9];

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    req_v    = 4'b0000;
    data_v   = 16'h0000;
    n_checks = 0;
    n_errors = 0;

    // 1: reset holds everything low even with all requests up.
    rst    = 1'b1;
    req_v  = 4'b1111;
    data_v = 16'h4321;
    tick();
    tick();
    expect_a("t1_rst", 1'b0, 2'd0, 4'h0);
    check_val("t1_rst.sel", {14'd0, bus_a.Sel}, 16'd0);
    rst = 1'b0;
    tick();
    expect_a("t1_first", 1'b1, 2'd0, 4'h1);

    // 2: sole requester FD, re-granted without a gap, data tracked.
    do_reset();
    req_v  = 4'b0010;
    data_v = 16'h00A0;
    tick();
    expect_a("t2_c1", 1'b1, 2'd1, 4'hA);
    for (int i = 2; i <= 5; i++) begin
      tick();
      expect_a($sformatf("t2_c%0d", i), 1'b1, 2'd1, 4'hA);
    end
    data_v = 16'h0050;
    tick();
    expect_a("t2_track", 1'b1, 2'd1, 4'h5);

    // 3: round robin on dut_b (hold 2), Enable never drops.
    do_reset();
    rr_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    req_v  = 4'b1111;
    data_v = 16'h4321;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_val($sformatf("t3_en%0d", i),  {15'd0, bus_b.Enable},    16'd1);
      check_val($sformatf("t3_sel%0d", i), {14'd0, bus_b.Sel},       {14'd0, rr_sel[i]});
      check_val($sformatf("t3_mux%0d", i), {12'd0, bus_b.muxOutput}, {14'd0, rr_sel[i]} + 16'd1);
    end

    // 4: early release of ch2 hands to ch3, then ch0, no bubble.
    do_reset();
    data_v = 16'h4321;
    req_v  = 4'b0100;
    tick();
    expect_a("t4_g2", 1'b1, 2'd2, 4'h3);
    req_v = 4'b1101;
    tick();
    expect_a("t4_hold", 1'b1, 2'd2, 4'h3);
    req_v = 4'b1001;
    tick();
    expect_a("t4_g3", 1'b1, 2'd3, 4'h4);
    req_v = 4'b0001;
    tick();
    expect_a("t4_g0", 1'b1, 2'd0, 4'h1);

    // 5: timeout and drop together advance rr_ptr once (next is ch1, not ch2).
    do_reset();
    data_v = 16'h4321;
    req_v  = 4'b0111;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_a($sformatf("t5_c%0d", i), 1'b1, 2'd0, 4'h1);
    end
    req_v = 4'b0110;
    tick();
    expect_a("t5_coll", 1'b1, 2'd1, 4'h2);
    req_v = 4'b0100;
    tick();
    expect_a("t5_next", 1'b1, 2'd2, 4'h3);
    req_v = 4'b0000;
    tick();
    expect_a("t5_idle", 1'b0, 2'd0, 4'h0);

    // 6: reset mid-grant on ch3 drops the link and restarts from ch0.
    do_reset();
    data_v = 16'h4321;
    req_v  = 4'b0010;
    tick();
    expect_a("t6_g1", 1'b1, 2'd1, 4'h2);
    req_v = 4'b1000;
    tick();
    expect_a("t6_g3", 1'b1, 2'd3, 4'h4);
    rst = 1'b1;
    tick();
    expect_a("t6_rst", 1'b0, 2'd0, 4'h0);
    check_val("t6_rst.sel", {14'd0, bus_a.Sel}, 16'd0);
    rst   = 1'b0;
    req_v = 4'b1111;
    tick();
    expect_a("t6_restart", 1'b1, 2'd0, 4'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
